// File: rtl/render_stream_driver.sv
// Stream initiator for the shape renderer: programs five config words, then raster-scans background pixels.
// Optional backpressure on the ready input is enabled by defining RENDER_DRIVER_STALL_EN.
module render_stream_driver #(
    parameter int X_MAX    = 1079,
    parameter int Y_MAX    = 2159,
    parameter int NUM_REGS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] cfg_x,
    input  logic [31:0] cfg_y,
    input  logic [31:0] cfg_w,
    input  logic [31:0] cfg_h,
    input  logic [31:0] cfg_color,
    input  logic [31:0] bg_color,
`ifdef RENDER_DRIVER_STALL_EN
    input  logic        ready,
`endif
    output logic        program_out,
    output logic        pix_valid,
    output logic [10:0] x_out,
    output logic [11:0] y_out,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        PROGRAM,
        SCAN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] cfg_words [5];
    logic [31:0] bg_reg;
    logic        capture;

    logic        program_nxt;
    logic        valid_nxt;
    logic [10:0] x_nxt;
    logic [11:0] y_nxt;
    logic [31:0] data_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    logic        advance;
    logic        last_reg;
    logic        y_at_max;
    logic        x_at_max;
    logic [2:0]  prog_idx_nxt;
    logic [31:0] next_word;

`ifdef RENDER_DRIVER_STALL_EN
    assign advance = pix_valid & ready;
`else
    assign advance = 1'b1;
`endif

    // The output registers double as the beat counters: y_out holds the config index while programming.
    assign last_reg     = (y_out == 12'(NUM_REGS - 1));
    assign y_at_max     = (y_out == 12'(Y_MAX));
    assign x_at_max     = (x_out == 11'(X_MAX));
    assign prog_idx_nxt = y_out[2:0] + 3'd1;

    always_comb begin
        next_word = '0;
        case (prog_idx_nxt)
            3'd0:    next_word = cfg_words[0];
            3'd1:    next_word = cfg_words[1];
            3'd2:    next_word = cfg_words[2];
            3'd3:    next_word = cfg_words[3];
            3'd4:    next_word = cfg_words[4];
            default: next_word = '0;
        endcase
    end

    // Defaults hold the current beat, which is exactly what a stalled beat needs.
    always_comb begin
        state_nxt   = state;
        program_nxt = program_out;
        valid_nxt   = pix_valid;
        x_nxt       = x_out;
        y_nxt       = y_out;
        data_nxt    = data_out;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        capture     = 1'b0;

        case (state)
            IDLE: begin
                program_nxt = 1'b0;
                valid_nxt   = 1'b0;
                x_nxt       = '0;
                y_nxt       = '0;
                data_nxt    = '0;
                busy_nxt    = 1'b0;
                if (start) begin
                    capture     = 1'b1;
                    state_nxt   = PROGRAM;
                    program_nxt = 1'b1;
                    valid_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    data_nxt    = cfg_x;
                end
            end

            PROGRAM: begin
                if (advance) begin
                    if (last_reg) begin
                        state_nxt   = SCAN;
                        program_nxt = 1'b0;
                        x_nxt       = '0;
                        y_nxt       = '0;
                        data_nxt    = bg_reg;
                    end else begin
                        y_nxt    = y_out + 12'd1;
                        data_nxt = next_word;
                    end
                end
            end

            SCAN: begin
                if (advance) begin
                    if (x_at_max && y_at_max) begin
                        state_nxt   = DONE;
                        program_nxt = 1'b0;
                        valid_nxt   = 1'b0;
                        x_nxt       = '0;
                        y_nxt       = '0;
                        data_nxt    = '0;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
                    end else if (y_at_max) begin
                        y_nxt = '0;
                        x_nxt = x_out + 11'd1;
                    end else begin
                        y_nxt = y_out + 12'd1;
                    end
                end
            end

            DONE: begin
                state_nxt   = IDLE;
                program_nxt = 1'b0;
                valid_nxt   = 1'b0;
                x_nxt       = '0;
                y_nxt       = '0;
                data_nxt    = '0;
                busy_nxt    = 1'b0;
            end

            default: begin
                state_nxt   = IDLE;
                program_nxt = 1'b0;
                valid_nxt   = 1'b0;
                x_nxt       = '0;
                y_nxt       = '0;
                data_nxt    = '0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            program_out <= 1'b0;
            pix_valid   <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            data_out    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            program_out <= program_nxt;
            pix_valid   <= valid_nxt;
            x_out       <= x_nxt;
            y_out       <= y_nxt;
            data_out    <= data_nxt;
            busy        <= busy_nxt;
            frame_done  <= done_nxt;
        end
    end

    // Config is latched only on the accepting edge so mid-frame input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                cfg_words[i] <= '0;
            end
            bg_reg <= '0;
        end else if (capture) begin
            cfg_words[0] <= cfg_x;
            cfg_words[1] <= cfg_y;
            cfg_words[2] <= cfg_w;
            cfg_words[3] <= cfg_h;
            cfg_words[4] <= cfg_color;
            bg_reg       <= bg_color;
        end
    end

endmodule

// File: tb/tb_render_stream_driver.sv
// Self-checking bench for render_stream_driver using a small 4x6 frame and a beat scoreboard.
// Exercises the stall path when RENDER_DRIVER_STALL_EN is defined.
module tb_render_stream_driver;

    localparam int XM = 3;
    localparam int YM = 5;
    localparam int NR = 5;

    typedef struct packed {
        logic        prog;
        logic [10:0] x;
        logic [11:0] y;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] cx;
        logic [31:0] cy;
        logic [31:0] cw;
        logic [31:0] ch;
        logic [31:0] cc;
        logic [31:0] bg;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] cfg_x, cfg_y, cfg_w, cfg_h, cfg_color, bg_color;
    logic        ready = 1'b1;
    logic        program_out, pix_valid, busy, frame_done;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;

    int    n_checks = 0;
    int    n_errors = 0;
    int    beat_cnt = 0;
    int    done_cnt = 0;
    bit    mon_en   = 1'b0;
    bit    done_prev = 1'b0;
    beat_t exp_q[$];
    vec_t  vecs[4];

    always #5 clk = ~clk;

    render_stream_driver #(
        .X_MAX   (XM),
        .Y_MAX   (YM),
        .NUM_REGS(NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .cfg_color  (cfg_color),
        .bg_color   (bg_color),
`ifdef RENDER_DRIVER_STALL_EN
        .ready      (ready),
`endif
        .program_out(program_out),
        .pix_valid  (pix_valid),
        .x_out      (x_out),
        .y_out      (y_out),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beats are popped only when accepted; a stalled beat must match the head without consuming it.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_beat: got prog=%0d x=%0d y=%0d data=%0h with empty scoreboard",
                             program_out, x_out, y_out, data_out);
                end else if (ready) begin
                    checkOutput("beat", {program_out, x_out, y_out, data_out}, exp_q.pop_front());
                    beat_cnt++;
                end else begin
                    checkOutput("held_beat", {program_out, x_out, y_out, data_out}, exp_q[0]);
                end
                checkOutput("busy_in_beat", busy, 1);
            end
            if (frame_done) begin
                done_cnt++;
                checkOutput("done_outputs_zero", {pix_valid, busy, program_out, x_out, y_out, data_out}, 0);
                checkOutput("done_queue_empty", exp_q.size(), 0);
                if (done_prev) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL done_pulse_width: got 2+ cycles expected 1");
                end
            end
            done_prev = frame_done;
        end else begin
            done_prev = 1'b0;
        end
    end

    // Called just after a rising edge; leaves the bench just after the edge that accepts start.
    task automatic applyStimulus(input vec_t v);
        beat_t b;
        logic [31:0] words [5];
        words[0] = v.cx;
        words[1] = v.cy;
        words[2] = v.cw;
        words[3] = v.ch;
        words[4] = v.cc;
        for (int k = 0; k < NR; k++) begin
            b = '{prog: 1'b1, x: 11'd0, y: 12'(k), data: words[k]};
            exp_q.push_back(b);
        end
        for (int xi = 0; xi <= XM; xi++) begin
            for (int yi = 0; yi <= YM; yi++) begin
                b = '{prog: 1'b0, x: 11'(xi), y: 12'(yi), data: v.bg};
                exp_q.push_back(b);
            end
        end
        cfg_x     = v.cx;
        cfg_y     = v.cy;
        cfg_w     = v.cw;
        cfg_h     = v.ch;
        cfg_color = v.cc;
        bg_color  = v.bg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int prev);
        int i;
        for (i = 0; i < 200 && done_cnt == prev; i++) @(negedge clk);
        checkOutput({name, "_done_seen"}, (done_cnt > prev), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic runFrameChecks(input string name, input vec_t v, input int pb, input int pd);
        repeat (4) @(posedge clk);
        #1;
        checkOutput({name, "_beats"}, beat_cnt - pb, v.exp_beats);
        checkOutput({name, "_done_count"}, done_cnt - pd, v.exp_done);
        checkOutput({name, "_idle_after"}, {busy, pix_valid}, 0);
    endtask

    initial begin
        int pb, pd, i;
        vecs[0] = '{32'd540, 32'd1080, 32'd270, 32'd540, 32'hFF0000FF, 32'h11223344, 29, 1};
        vecs[1] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 29, 1};
        vecs[2] = '{32'hFFFFFFFF, 32'h1, 32'h2, 32'h3, 32'hDEADBEEF, 32'hA5A5A5A5, 29, 1};
        vecs[3] = '{32'd1079, 32'd2159, 32'h80000000, 32'h7FFFFFFF, 32'h00FF00FF, 32'h0, 29, 1};

        rst_n = 1'b0;
        start = 1'b0;
        cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_color = '0; bg_color = '0;
        ready = 1'b1;
        #12;
        checkOutput("reset_outputs", {pix_valid, busy, program_out, frame_done, x_out, y_out, data_out}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_no_beat", {busy, pix_valid, frame_done}, 0);

        for (int n = 0; n < 4; n++) begin
            pb = beat_cnt;
            pd = done_cnt;
            applyStimulus(vecs[n]);
            waitDone($sformatf("frame%0d", n), pd);
            runFrameChecks($sformatf("frame%0d", n), vecs[n], pb, pd);
        end

        // start re-pulsed mid-scan together with new cfg values must not disturb the frame
        pb = beat_cnt;
        pd = done_cnt;
        applyStimulus(vecs[2]);
        repeat (10) @(posedge clk);
        #1;
        cfg_x = 32'h12345678;
        bg_color = 32'hCAFEF00D;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("start_in_scan", pd);
        repeat (8) @(posedge clk);
        #1;
        runFrameChecks("start_in_scan", vecs[2], pb, pd);

        // asynchronous reset at pixel (1,2)
        pd = done_cnt;
        applyStimulus(vecs[0]);
        for (i = 0; i < 100; i++) begin
            if (pix_valid && !program_out && x_out == 11'd1 && y_out == 12'd2) break;
            @(posedge clk);
            #1;
        end
        checkOutput("reached_pixel_1_2", (i < 100), 1);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {pix_valid, busy, program_out, frame_done, x_out, y_out, data_out}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", {busy, pix_valid, frame_done}, 0);
        checkOutput("no_done_after_reset", done_cnt - pd, 0);

        pb = beat_cnt;
        pd = done_cnt;
        applyStimulus(vecs[1]);
        waitDone("restart", pd);
        runFrameChecks("restart", vecs[1], pb, pd);

`ifdef RENDER_DRIVER_STALL_EN
        pb = beat_cnt;
        pd = done_cnt;
        applyStimulus(vecs[0]);
        for (i = 0; i < 20; i++) begin
            if (pix_valid && program_out && y_out == 12'd2) break;
            @(posedge clk);
            #1;
        end
        checkOutput("reached_prog_beat2", (i < 20), 1);
        ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_held_beat", {program_out, y_out, data_out}, {1'b1, 12'd2, vecs[0].cw});
        ready = 1'b1;
        waitDone("stall", pd);
        runFrameChecks("stall", vecs[0], pb, pd);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
